adsr_poly_envelope: RTL and testbench

- Parametrised multi-voice ADSR envelope generator and mixer; successor to the single-voice ADSR stage between the music player and the codec.
- Each voice has its own gate and a five-state envelope FSM, updated once per input sample strobe.
- One shared multiplier scales each voice's sample by its envelope, one voice per cycle.
- Also produces a saturated mix of all voices, which drives the codec and wave display.

---
 rtl/adsr_pkg.sv | 30 +++
 rtl/adsr_env_voice.sv | 103 ++++++++++
 rtl/adsr_poly_envelope.sv | 138 +++++++++++++
 tb/tb_adsr_poly_envelope.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - shared state encoding and scaling limits for the ADSR envelope slice
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    // Headroom bits on the mix accumulator: enough for up to 8 full-scale voices.
    localparam int ACC_GUARD = 3;

    // Full-scale envelope value for a given envelope width (widths up to 32).
    function automatic logic [31:0] env_max(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    // Largest positive mix value for a signed sample width.
    function automatic int mix_hi(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    // Most negative mix value for a signed sample width.
    function automatic int mix_lo(input int w);
        return -(1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/adsr_env_voice.sv
// rtl/adsr_env_voice.sv - one voice's ADSR state machine, envelope and gate history
module adsr_env_voice
    import adsr_pkg::*;
#(
    parameter int ENV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_update,
    input  logic                 i_gate,
    input  logic [ENV_WIDTH-1:0] i_attack_step,
    input  logic [ENV_WIDTH-1:0] i_decay_step,
    input  logic [ENV_WIDTH-1:0] i_sustain_level,
    input  logic [ENV_WIDTH-1:0] i_release_step,
    output logic [ENV_WIDTH-1:0] o_env,
    output logic                 o_active
);

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = ENV_WIDTH'(env_max(ENV_WIDTH));

    adsr_state_t          r_state;
    adsr_state_t          w_state_next;
    adsr_state_t          w_eff_state;
    logic [ENV_WIDTH-1:0] r_env;
    logic [ENV_WIDTH-1:0] w_env_next;
    logic                 r_gate_prev;
    logic                 w_gate_prev_next;

    // One extra bit so attack overflow and the decay threshold compare cleanly.
    logic [ENV_WIDTH:0]   w_attack_sum;
    logic [ENV_WIDTH:0]   w_decay_limit;

    assign w_attack_sum  = {1'b0, r_env} + {1'b0, i_attack_step};
    assign w_decay_limit = {1'b0, i_decay_step} + {1'b0, i_sustain_level};

    // State, envelope and previous gate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_env       <= '0;
            r_gate_prev <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_env       <= w_env_next;
            r_gate_prev <= w_gate_prev_next;
        end
    end

    // Gate edges pick the effective state first, then that state's step is applied.
    always_comb begin
        w_state_next     = r_state;
        w_env_next       = r_env;
        w_gate_prev_next = r_gate_prev;
        w_eff_state      = r_state;
        if (i_update) begin
            w_gate_prev_next = i_gate;
            if (i_gate && !r_gate_prev) begin
                w_eff_state = ST_ATTACK;
            end else if (!i_gate && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                                     r_state == ST_SUSTAIN)) begin
                w_eff_state = ST_RELEASE;
            end
            w_state_next = w_eff_state;
            case (w_eff_state)
                ST_ATTACK: begin
                    if (i_attack_step == '0 || w_attack_sum >= {1'b0, ENV_MAX}) begin
                        w_env_next   = ENV_MAX;
                        w_state_next = ST_DECAY;
                    end else begin
                        w_env_next = w_attack_sum[ENV_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    if (i_decay_step == '0 || {1'b0, r_env} <= w_decay_limit) begin
                        w_env_next   = i_sustain_level;
                        w_state_next = ST_SUSTAIN;
                    end else begin
                        w_env_next = r_env - i_decay_step;
                    end
                end
                ST_SUSTAIN: begin
                    w_env_next = i_sustain_level;
                end
                ST_RELEASE: begin
                    if (i_release_step == '0 || r_env <= i_release_step) begin
                        w_env_next   = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_env_next = r_env - i_release_step;
                    end
                end
                default: begin
                    w_env_next   = '0;
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign o_env    = r_env;
    assign o_active = (r_state != ST_IDLE);

endmodule

// File: rtl/adsr_poly_envelope.sv
// rtl/adsr_poly_envelope.sv - multi-voice ADSR envelope, shared scaler and saturating mixer
module adsr_poly_envelope
    import adsr_pkg::*;
#(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ENV_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_VOICES-1:0]              gate,
    input  logic [ENV_WIDTH-1:0]               attack_step,
    input  logic [ENV_WIDTH-1:0]               decay_step,
    input  logic [ENV_WIDTH-1:0]               sustain_level,
    input  logic [ENV_WIDTH-1:0]               release_step,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_in,
    input  logic                               in_ready,
    output logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_out,
    output logic [SAMPLE_WIDTH-1:0]            mix_out,
    output logic                               out_ready,
    output logic [NUM_VOICES-1:0]              voice_active,
    output logic                               overrun
);

    localparam int IDXW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACCW  = SAMPLE_WIDTH + ACC_GUARD;
    localparam int PRODW = SAMPLE_WIDTH + ENV_WIDTH + 1;
    localparam logic signed [ACCW-1:0] MIX_HI   = ACCW'(mix_hi(SAMPLE_WIDTH));
    localparam logic signed [ACCW-1:0] MIX_LO   = ACCW'(mix_lo(SAMPLE_WIDTH));
    localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(NUM_VOICES - 1);

    logic                               r_busy;
    logic                               r_update;
    logic [IDXW-1:0]                    r_idx;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] r_samples;
    logic [NUM_VOICES-1:0]              r_gate;
    logic signed [ACCW-1:0]             r_acc;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] r_sample_out;
    logic [SAMPLE_WIDTH-1:0]            r_mix;
    logic                               r_out_ready;
    logic                               r_overrun;

    logic                               w_accept;
    logic                               w_update;
    logic [ENV_WIDTH-1:0]               w_env [NUM_VOICES];
    logic [NUM_VOICES-1:0]              w_active;
    logic signed [SAMPLE_WIDTH-1:0]     w_sample_s;
    logic signed [ENV_WIDTH:0]          w_env_s;
    logic signed [PRODW-1:0]            w_prod;
    logic signed [SAMPLE_WIDTH-1:0]     w_scaled;
    logic signed [ACCW-1:0]             w_acc_next;
    logic [SAMPLE_WIDTH-1:0]            w_mix_sat;

    assign w_accept = in_ready && !r_busy;
    assign w_update = r_busy && r_update;

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
        adsr_env_voice #(
            .ENV_WIDTH (ENV_WIDTH)
        ) u_voice (
            .clk             (clk),
            .reset           (reset),
            .i_update        (w_update),
            .i_gate          (r_gate[gv]),
            .i_attack_step   (attack_step),
            .i_decay_step    (decay_step),
            .i_sustain_level (sustain_level),
            .i_release_step  (release_step),
            .o_env           (w_env[gv]),
            .o_active        (w_active[gv])
        );
    end

    // Shared scaler: the envelope is zero-extended so it multiplies as a positive value.
    assign w_sample_s = r_samples[int'(r_idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign w_env_s    = {1'b0, w_env[r_idx]};
    assign w_prod     = PRODW'(w_sample_s) * PRODW'(w_env_s);
    // The floored quotient always fits the sample width since env < 2^ENV_WIDTH.
    assign w_scaled   = SAMPLE_WIDTH'(w_prod >>> ENV_WIDTH);
    assign w_acc_next = r_acc + ACCW'(w_scaled);

    // Clamp the final sum into the signed sample range.
    always_comb begin
        w_mix_sat = w_acc_next[SAMPLE_WIDTH-1:0];
        if (w_acc_next > MIX_HI) begin
            w_mix_sat = MIX_HI[SAMPLE_WIDTH-1:0];
        end else if (w_acc_next < MIX_LO) begin
            w_mix_sat = MIX_LO[SAMPLE_WIDTH-1:0];
        end
    end

    // Pass sequencer: latch, one update cycle, then one voice per cycle into the mix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_update     <= 1'b0;
            r_idx        <= '0;
            r_samples    <= '0;
            r_gate       <= '0;
            r_acc        <= '0;
            r_sample_out <= '0;
            r_mix        <= '0;
            r_out_ready  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_out_ready <= 1'b0;
            r_overrun   <= in_ready && r_busy;
            if (w_accept) begin
                r_busy    <= 1'b1;
                r_update  <= 1'b1;
                r_samples <= sample_in;
                r_gate    <= gate;
                r_acc     <= '0;
                r_idx     <= '0;
            end else if (r_update) begin
                r_update <= 1'b0;
                r_idx    <= '0;
            end else if (r_busy) begin
                r_sample_out[int'(r_idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= w_scaled;
                r_acc <= w_acc_next;
                if (r_idx == LAST_IDX) begin
                    r_mix       <= w_mix_sat;
                    r_out_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign sample_out   = r_sample_out;
    assign mix_out      = r_mix;
    assign out_ready    = r_out_ready;
    assign overrun      = r_overrun;
    assign voice_active = w_active;

endmodule

// File: tb/tb_adsr_poly_envelope.sv
// tb/tb_adsr_poly_envelope.sv - directed self-checking bench for adsr_poly_envelope
module tb_adsr_poly_envelope;

    localparam int NV = 2;
    localparam int SW = 16;
    localparam int EW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NV-1:0]     gate;
    logic [EW-1:0]     attack_step;
    logic [EW-1:0]     decay_step;
    logic [EW-1:0]     sustain_level;
    logic [EW-1:0]     release_step;
    logic [NV*SW-1:0]  sample_in;
    logic              in_ready;
    logic [NV*SW-1:0]  sample_out;
    logic [SW-1:0]     mix_out;
    logic              out_ready;
    logic [NV-1:0]     voice_active;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adsr_poly_envelope #(
        .NUM_VOICES   (NV),
        .SAMPLE_WIDTH (SW),
        .ENV_WIDTH    (EW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .sample_in     (sample_in),
        .in_ready      (in_ready),
        .sample_out    (sample_out),
        .mix_out       (mix_out),
        .out_ready     (out_ready),
        .voice_active  (voice_active),
        .overrun       (overrun)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input string tag, input logic [1:0] g,
                            input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] em);
        int lat;
        tick();
        gate      = g;
        sample_in = {s1, s0};
        in_ready  = 1'b1;
        tick();
        in_ready = 1'b0;
        lat = 1;
        while (!out_ready && lat < 12) begin
            tick();
            lat++;
        end
        check($sformatf("%s latency", tag), lat, 4);
        check($sformatf("%s v0", tag), sample_out[15:0], e0);
        check($sformatf("%s v1", tag), sample_out[31:16], e1);
        check($sformatf("%s mix", tag), mix_out, em);
    endtask

    initial begin
        int lat;
        int npulse;
        logic [15:0] env;

        reset         = 1'b1;
        in_ready      = 1'b0;
        gate          = '0;
        sample_in     = '0;
        attack_step   = 16'h4000;
        decay_step    = 16'h1000;
        sustain_level = 16'h8000;
        release_step  = 16'h2000;
        #1;
        check("rst sample_out", sample_out, 0);
        check("rst mix_out", mix_out, 0);
        check("rst out_ready", out_ready, 0);
        check("rst voice_active", voice_active, 0);
        check("rst overrun", overrun, 0);
        tick();
        tick();
        reset = 1'b0;

        // Attack: 0x4000, 0x8000, 0xC000, 0xFFFF
        run_pass("atk1", 2'b01, 16'h4000, 16'h0, 16'h1000, 16'h0, 16'h1000);
        check("atk active", voice_active, 2'b01);
        run_pass("atk2", 2'b01, 16'h4000, 16'h0, 16'h2000, 16'h0, 16'h2000);
        run_pass("atk3", 2'b01, 16'h4000, 16'h0, 16'h3000, 16'h0, 16'h3000);
        run_pass("atk4", 2'b01, 16'h8000, 16'h0, 16'h8000, 16'h0, 16'h8000);

        // Decay 0xEFFF..0x8FFF, then clamp to sustain 0x8000
        for (int k = 1; k <= 7; k++) begin
            env = 16'hFFFF - 16'(k * 16'h1000);
            run_pass($sformatf("dec%0d", k), 2'b01, 16'h4000, 16'h0,
                     env >> 2, 16'h0, env >> 2);
        end
        run_pass("dec8", 2'b01, 16'h4000, 16'h0, 16'h2000, 16'h0, 16'h2000);
        run_pass("sus1", 2'b01, 16'h7FFF, 16'h0, 16'h3FFF, 16'h0, 16'h3FFF);
        run_pass("sus2", 2'b01, 16'h4000, 16'h0, 16'h2000, 16'h0, 16'h2000);

        // Release then retrigger from 0x4000
        run_pass("rel1", 2'b00, 16'h4000, 16'h0, 16'h1800, 16'h0, 16'h1800);
        run_pass("rel2", 2'b00, 16'h4000, 16'h0, 16'h1000, 16'h0, 16'h1000);
        run_pass("retrig", 2'b01, 16'h4000, 16'h0, 16'h2000, 16'h0, 16'h2000);

        // Release all the way to idle
        run_pass("fall1", 2'b00, 16'h4000, 16'h0, 16'h1800, 16'h0, 16'h1800);
        run_pass("fall2", 2'b00, 16'h4000, 16'h0, 16'h1000, 16'h0, 16'h1000);
        run_pass("fall3", 2'b00, 16'h4000, 16'h0, 16'h0800, 16'h0, 16'h0800);
        check("fall3 active", voice_active, 2'b01);
        run_pass("fall4", 2'b00, 16'h4000, 16'h0, 16'h0000, 16'h0, 16'h0000);
        check("fall4 active", voice_active, 2'b00);

        // Mix saturation with both voices held at env 0xFFFF
        attack_step   = 16'h0000;
        decay_step    = 16'h0000;
        sustain_level = 16'hFFFF;
        run_pass("mix_hi", 2'b11, 16'h7001, 16'h7001, 16'h7000, 16'h7000, 16'h7FFF);
        run_pass("mix_lo", 2'b11, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h8000);
        run_pass("mix_zero", 2'b11, 16'h1001, 16'hF000, 16'h1000, 16'hF000, 16'h0000);
        check("mix active", voice_active, 2'b11);

        // Overrun: strobes in two consecutive cycles
        tick();
        gate      = 2'b11;
        sample_in = {16'h0, 16'h1001};
        in_ready  = 1'b1;
        tick();
        check("ovr first", overrun, 0);
        tick();
        in_ready = 1'b0;
        check("ovr pulse", overrun, 1);
        tick();
        check("ovr clear", overrun, 0);
        npulse = 0;
        lat    = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_ready) begin
                npulse++;
                lat = 3 + i;
            end
            tick();
        end
        check("ovr out_ready count", npulse, 1);
        check("ovr latency", lat, 4);
        check("ovr v0", sample_out[15:0], 16'h1000);

        // in_ready coincident with out_ready is accepted
        sample_in = {16'h0, 16'h1001};
        in_ready  = 1'b1;
        tick();
        in_ready = 1'b0;
        lat = 1;
        while (!out_ready && lat < 12) begin
            tick();
            lat++;
        end
        check("coin first latency", lat, 4);
        check("coin first v0", sample_out[15:0], 16'h1000);
        sample_in = {16'h0, 16'h2001};
        in_ready  = 1'b1;
        tick();
        in_ready = 1'b0;
        check("coin overrun", overrun, 0);
        lat = 1;
        while (!out_ready && lat < 12) begin
            tick();
            lat++;
        end
        check("coin second latency", lat, 4);
        check("coin second v0", sample_out[15:0], 16'h2000);
        check("coin second mix", mix_out, 16'h2000);

        // Reset in the middle of a pass
        attack_step = 16'h4000;
        tick();
        gate      = 2'b01;
        sample_in = {16'h0, 16'h4000};
        in_ready  = 1'b1;
        tick();
        in_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midrst sample_out", sample_out, 0);
        check("midrst mix_out", mix_out, 0);
        check("midrst voice_active", voice_active, 0);
        check("midrst out_ready", out_ready, 0);
        tick();
        tick();
        reset  = 1'b0;
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_ready) npulse++;
            tick();
        end
        check("midrst no out_ready", npulse, 0);
        run_pass("post_rst", 2'b01, 16'h4000, 16'h0, 16'h1000, 16'h0, 16'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
